// File: rtl/nn_pkg.sv
// Shared constants and types for the output-layer bias path (ROM and loader).
package nn_pkg;

    localparam int unsigned NUM_BIAS    = 10;
    localparam int unsigned BIAS_W      = 16;
    localparam int unsigned BIAS_ADDR_W = 4;

    // Loader control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bias_regfile.sv
// Bias storage: async-reset entries, one synchronous write port and a
// combinational read port that returns zero outside the populated range.
module bias_regfile #(
    parameter int unsigned NUM_ENTRIES = nn_pkg::NUM_BIAS,
    parameter int unsigned DATA_W      = nn_pkg::BIAS_W,
    parameter int unsigned ADDR_W      = nn_pkg::BIAS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] N_ENTRIES = (ADDR_W + 1)'(NUM_ENTRIES);

    logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
    logic [DATA_W-1:0] mem_d [NUM_ENTRIES];

    // Next contents: only the addressed in-range entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (we && ({1'b0, waddr} < N_ENTRIES)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Entry registers, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read, zero for addresses past the last entry
    always_comb begin
        rdata = '0;
        if ({1'b0, raddr} < N_ENTRIES) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/bias_loader.sv
// Runtime bias loader: assembles little-endian 16-bit words from a byte
// stream and writes them into the bias register file, exposing the same
// addr->data read port as the bias ROM.
module bias_loader #(
    parameter int unsigned NUM_BIAS = nn_pkg::NUM_BIAS,
    parameter int unsigned DATA_W   = nn_pkg::BIAS_W,
    parameter int unsigned ADDR_W   = nn_pkg::BIAS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_loaded,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    import nn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BIAS - 1);

    loader_state_t     state_q, state_d;
    logic              hi_phase_q, hi_phase_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] words_loaded_q, words_loaded_d;
    logic              we;
    logic              accept;

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign words_loaded = words_loaded_q;
    assign accept       = in_valid & in_ready;

    // Next state, byte assembly and write strobe; start overrides any byte
    always_comb begin
        state_d        = state_q;
        hi_phase_d     = hi_phase_q;
        lo_byte_d      = lo_byte_q;
        wr_ptr_d       = wr_ptr_q;
        words_loaded_d = words_loaded_q;
        we             = 1'b0;

        if (start) begin
            state_d        = S_LOAD;
            hi_phase_d     = 1'b0;
            wr_ptr_d       = '0;
            words_loaded_d = '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (accept) begin
                        hi_phase_d = ~hi_phase_q;
                        if (!hi_phase_q) begin
                            lo_byte_d = in_data;
                        end else begin
                            we             = 1'b1;
                            words_loaded_d = words_loaded_q + ADDR_W'(1);
                            // Pointer holds at the last entry; leaving LOAD
                            // keeps it from wrapping.
                            if (wr_ptr_q == LAST_PTR) begin
                                state_d = S_DONE;
                            end else begin
                                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and assembly registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hi_phase_q     <= 1'b0;
            lo_byte_q      <= '0;
            wr_ptr_q       <= '0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            hi_phase_q     <= hi_phase_d;
            lo_byte_q      <= lo_byte_d;
            wr_ptr_q       <= wr_ptr_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    bias_regfile #(
        .NUM_ENTRIES (NUM_BIAS),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({in_data, lo_byte_q}),
        .raddr (addr),
        .rdata (data)
    );

endmodule

// File: doc/bias_loader.md
# bias_loader

Writer-side counterpart to the bias ROM. Receives bias values as a byte stream over a valid/ready handshake, assembles little-endian 16-bit words, and stores them in a 10-entry register file. Exposes the same combinational `addr`→`data` read port as the bias ROM, so the output layer can switch to runtime-loaded biases without interface changes.

## Interface
**Parameters**
- `NUM_BIAS`, 10: number of bias entries.
- `DATA_W`, 16: bias word width.
- `ADDR_W`, 4: read/write address width.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous reset, active-high.
- `start`, input, 1: single-cycle pulse that begins or restarts a load.
- `in_valid`, input, 1: byte-stream valid.
- `in_data`, input, 8: byte-stream data.
- `in_ready`, output, 1: byte-stream ready.
- `busy`, output, 1: high while in LOAD.
- `done`, output, 1: high once all `NUM_BIAS` words are written; held until the next `start` or `rst`.
- `words_loaded`, output, ADDR_W: count of words written in the current load.
- `addr`, input, ADDR_W: read address.
- `data`, output, DATA_W: read data. Combinational from the register file.

## Operation
- **States.**
  - IDLE → LOAD on `start`.
  - LOAD → DONE when word `NUM_BIAS-1` is written.
  - DONE → LOAD on `start`.
- **Handshake.**
  - `in_ready` = (state == LOAD).
  - A byte is accepted when `in_valid & in_ready`.
  - Bytes offered in IDLE or DONE are not accepted. They are not lost, because `in_ready` is low.
- **Byte phase.**
  - A 1-bit `hi_phase` register starts at 0.
  - On an accepted byte with `hi_phase`=0, latch `lo_byte`.
  - On an accepted byte with `hi_phase`=1, write `{in_data, lo_byte}` to entry `wr_ptr`, increment `wr_ptr` and `words_loaded`.
  - `hi_phase` toggles on every accepted byte.
- **Start.**
  - `start` clears `wr_ptr`, `words_loaded`, `hi_phase` and `done`, then enters LOAD.
  - It does not clear stored entries. Entries are overwritten as new words arrive.
  - `start` in LOAD restarts the load from entry 0.
  - If `start` coincides with an accepted byte, `start` wins and that byte is discarded.
- **Read port.**
  - `data` = entry[`addr`] for `addr` < `NUM_BIAS`. `data` = 0 for `addr` ≥ `NUM_BIAS` (10..15).
  - Reads are never blocked by a load in progress.
- **Counter range.** `wr_ptr` never exceeds `NUM_BIAS-1`. There is no wrap-around, because LOAD exits at the final word.

## Timing
- **Reset values.**
  - State = IDLE.
  - `in_ready`=0, `busy`=0, `done`=0, `words_loaded`=0, `hi_phase`=0.
  - All entries = 0, so `data`=0 for every `addr`.
- **`in_ready` and `busy`.** Both rise one cycle after the `start` edge.
- **Write latency.** A written word appears on `data` the cycle after its high-byte handshake edge. In the handshake cycle itself, `data` still shows the old value.
- **Final word.** On the 10th word's high-byte edge, state goes to DONE. In the following cycle `done`=1, `busy`=0 and `in_ready`=0.
- **Throughput.** One byte per cycle, so a full load takes 20 accepted bytes (20 cycles minimum).
- **Reset mid-load.** Reset immediately returns everything to reset values, and any partial word is lost.
- **Stalls.** Gaps in `in_valid` stall the load indefinitely. There is no timeout.

## Structure
- **Shared package** `nn_pkg`:
  - `NUM_BIAS`, `BIAS_W` and `BIAS_ADDR_W` constants, shared with the bias ROM.
  - State encoding constants `S_IDLE`, `S_LOAD`, `S_DONE`.
- **Sub-module** `bias_regfile`:
  - Contents: 10×16 storage with an async reset, a single synchronous write port (`we`, `waddr`, `wdata`), and a combinational read port with out-of-range → 0.
  - The top level holds the FSM, the byte assembler and the counters.

## Test plan
- **Reset.**
  - Stimulus: assert `rst` and sweep `addr` 0..15.
  - Response: `data`=0x0000 everywhere; `in_ready`=0, `busy`=0, `done`=0.
- **Full load.**
  - Stimulus: `start`, then bytes 0x01,0x00, 0x02,0x00, … 0x0A,0x00 with `in_valid` held high.
  - Response: `done`=1 after the 20th byte; `words_loaded`=10; reading `addr` 0..9 gives `data` 0x0001..0x000A; `addr` 10..15 gives 0x0000.
- **Back-pressure and gaps.**
  - Stimulus: random `in_valid` gaps during a load of 0xBEEF to every entry; a byte offered in DONE.
  - Response: all 10 entries read 0xBEEF; the DONE-state byte is not accepted (`in_ready`=0).
- **Restart mid-load.**
  - Stimulus: after 3 words of 0x1111, pulse `start` coincident with a byte, then load 0x2222 ×10.
  - Response: the coincident byte is dropped; all entries read 0x2222; `words_loaded` reaches exactly 10.
- **Async reset mid-load.**
  - Stimulus: assert `rst` after 5 words, between a low byte and its high byte.
  - Response: outputs and entries immediately return to 0; a subsequent full load succeeds with correct byte pairing.
- **Read during write.**
  - Stimulus: hold `addr`=4 while word 4 (0x1234) is written.
  - Response: `data` shows the old value in the handshake cycle and 0x1234 in the next cycle.
